// File: rtl/ghost_mover.sv
// Ghost motion engine: tick divider, patrol/chase/frozen movement clamped to a box,
// and the raster fill for the sprite at the current position.
module ghost_mover #(
  parameter int GHOST_WIDTH = 23,
  parameter int TICK_DIV    = 500000,
  parameter int CNT_W       = 20,
  parameter int X_MIN       = 116,
  parameter int X_MAX       = 140,
  parameter int Y_MIN       = 90,
  parameter int Y_MAX       = 322,
  parameter int OFFSET_H    = 274,
  parameter int OFFSET_V    = 58
) (
  input  logic       move_clk,
  input  logic       reset,
  input  logic       level_reset,
  input  logic [9:0] xIni,
  input  logic [9:0] yIni,
  input  logic [4:0] speed,
  input  logic [1:0] mode,
  input  logic [9:0] targetX,
  input  logic [9:0] targetY,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic [9:0] ghostX,
  output logic [9:0] ghostY,
  output logic [1:0] direction,
  output logic       step,
  output logic       ghostFill
);

  localparam int HW = (GHOST_WIDTH - 1) / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic signed [11:0] XMIN_S = 12'(X_MIN);
  localparam logic signed [11:0] XMAX_S = 12'(X_MAX);
  localparam logic signed [11:0] YMIN_S = 12'(Y_MIN);
  localparam logic signed [11:0] YMAX_S = 12'(Y_MAX);

  localparam logic [10:0] HW_U  = 11'(HW);
  localparam logic [10:0] OFS_H = 11'(OFFSET_H);
  localparam logic [10:0] OFS_V = 11'(OFFSET_V);

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  logic [CNT_W-1:0] cnt_q;
  logic [9:0]       x_q, y_q;
  logic [9:0]       x_d, y_d;
  logic [1:0]       dir_q, dir_d;
  logic             step_q;

  logic             tick;
  logic [1:0]       dir_init;

  assign tick     = (cnt_q == CNT_LAST);
  assign dir_init = (mode == 2'b01) ? DIR_RIGHT : DIR_DOWN;

  // Chase distances, 11-bit two's complement, and their magnitudes.
  logic [10:0] dx, dy, adx, ady;

  assign dx  = {1'b0, targetX} - {1'b0, x_q};
  assign dy  = {1'b0, targetY} - {1'b0, y_q};
  assign adx = dx[10] ? (~dx + 11'd1) : dx;
  assign ady = dy[10] ? (~dy + 11'd1) : dy;

  logic [1:0]        dir_sel;
  logic              active, move_en, patrol;
  logic signed [11:0] spd, nx, ny;
  logic              x_lo, x_hi, y_lo, y_hi, rev;

  assign spd = {7'b0000000, speed};

  always_comb begin
    dir_sel = dir_q;
    active  = (mode != 2'b11);
    patrol  = (mode == 2'b00) || (mode == 2'b01);
    move_en = active;
    case (mode)
      2'b00: if (!dir_q[0]) dir_sel = DIR_DOWN;
      2'b01: if (dir_q[0])  dir_sel = DIR_RIGHT;
      2'b10: begin
        if ((adx >= ady) && (dx != 11'd0))
          dir_sel = dx[10] ? DIR_LEFT : DIR_RIGHT;
        else if (dy != 11'd0)
          dir_sel = dy[10] ? DIR_UP : DIR_DOWN;
        else
          move_en = 1'b0;
      end
      default: move_en = 1'b0;
    endcase
  end

  // One spare bit above the 11-bit range keeps out-of-box starts from wrapping.
  always_comb begin
    nx = {2'b00, x_q};
    ny = {2'b00, y_q};
    if (move_en) begin
      case (dir_sel)
        DIR_LEFT:  nx = nx - spd;
        DIR_RIGHT: nx = nx + spd;
        DIR_UP:    ny = ny - spd;
        default:   ny = ny + spd;
      endcase
    end
  end

  assign x_lo = (nx < XMIN_S);
  assign x_hi = (nx > XMAX_S);
  assign y_lo = (ny < YMIN_S);
  assign y_hi = (ny > YMAX_S);

  // Only a clamp on the axis being travelled reverses a patrol.
  assign rev = patrol && move_en &&
               ((!dir_sel[0] && (x_lo || x_hi)) || (dir_sel[0] && (y_lo || y_hi)));

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    dir_d = dir_q;
    if (active) begin
      x_d   = x_lo ? XMIN_S[9:0] : (x_hi ? XMAX_S[9:0] : nx[9:0]);
      y_d   = y_lo ? YMIN_S[9:0] : (y_hi ? YMAX_S[9:0] : ny[9:0]);
      dir_d = rev ? (dir_sel ^ 2'b10) : dir_sel;
    end
  end

  always_ff @(posedge move_clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      x_q    <= xIni;
      y_q    <= yIni;
      dir_q  <= dir_init;
      step_q <= 1'b0;
    end else if (level_reset) begin
      cnt_q  <= '0;
      x_q    <= xIni;
      y_q    <= yIni;
      dir_q  <= dir_init;
      step_q <= 1'b0;
    end else if (tick) begin
      cnt_q  <= '0;
      step_q <= 1'b1;
      x_q    <= x_d;
      y_q    <= y_d;
      dir_q  <= dir_d;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      step_q <= 1'b0;
    end
  end

  assign ghostX    = x_q;
  assign ghostY    = y_q;
  assign direction = dir_q;
  assign step      = step_q;

  // Sprite window; the lower bounds saturate at zero.
  logic [10:0] cx, cy, h_lo, h_hi, v_lo, v_hi;

  assign cx   = {1'b0, x_q} + OFS_H;
  assign cy   = {1'b0, y_q} + OFS_V;
  assign h_lo = (cx >= HW_U) ? (cx - HW_U) : 11'd0;
  assign h_hi = cx + HW_U;
  assign v_lo = (cy >= HW_U) ? (cy - HW_U) : 11'd0;
  assign v_hi = cy + HW_U;

  assign ghostFill = ({1'b0, hCount} >= h_lo) && ({1'b0, hCount} <= h_hi) &&
                     ({1'b0, vCount} >= v_lo) && ({1'b0, vCount} <= v_hi);

endmodule

// File: tb/tb_ghost_mover.sv
// Bench for ghost_mover: directed corner sequences, a fill vector table, and
// randomized cycles checked against a movement-rule reference model.
module tb_ghost_mover;

  localparam int TD   = 4;
  localparam int XMIN = 116, XMAX = 140, YMIN = 90, YMAX = 322;
  localparam int OFH  = 274, OFV = 58, HWD = 11;

  logic       move_clk = 1'b0;
  logic       reset = 1'b1;
  logic       level_reset = 1'b0;
  logic [9:0] xIni = 10'd120, yIni = 10'd100;
  logic [4:0] speed = 5'd5;
  logic [1:0] mode = 2'b00;
  logic [9:0] targetX = '0, targetY = '0, hCount = '0, vCount = '0;
  logic [9:0] ghostX, ghostY;
  logic [1:0] direction;
  logic       step, ghostFill;

  int n_tests = 0;
  int n_fail  = 0;

  int m_x, m_y, m_dir, m_cnt, m_step;

  ghost_mover #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .move_clk(move_clk), .reset(reset), .level_reset(level_reset),
    .xIni(xIni), .yIni(yIni), .speed(speed), .mode(mode),
    .targetX(targetX), .targetY(targetY), .hCount(hCount), .vCount(vCount),
    .ghostX(ghostX), .ghostY(ghostY), .direction(direction), .step(step),
    .ghostFill(ghostFill)
  );

  always #5 move_clk = ~move_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Apply one movement tick using the rules for the current mode.
  task automatic model_tick();
    int md, d, nx, ny, cx, cy, dx, dy;
    bit mv;
    md = int'(mode);
    if (md == 3) return;
    d  = m_dir;
    mv = 1;
    if (md == 0 && (d == 0 || d == 2)) d = 3;
    if (md == 1 && (d == 1 || d == 3)) d = 2;
    if (md == 2) begin
      dx = int'(targetX) - m_x;
      dy = int'(targetY) - m_y;
      if (absi(dx) >= absi(dy) && dx != 0) d = (dx > 0) ? 2 : 0;
      else if (dy != 0)                     d = (dy > 0) ? 3 : 1;
      else                                  mv = 0;
    end
    nx = m_x;
    ny = m_y;
    if (mv) begin
      if (d == 0) nx -= int'(speed);
      if (d == 2) nx += int'(speed);
      if (d == 1) ny -= int'(speed);
      if (d == 3) ny += int'(speed);
    end
    cx = clampi(nx, XMIN, XMAX);
    cy = clampi(ny, YMIN, YMAX);
    if (md < 2 && (((d % 2) == 0 && cx != nx) || ((d % 2) == 1 && cy != ny)))
      d = d ^ 2;
    m_x = cx;
    m_y = cy;
    m_dir = d;
  endtask

  task automatic do_reset(input int x, input int y, input int md, input int sp);
    xIni = 10'(x); yIni = 10'(y); mode = 2'(md); speed = 5'(sp);
    level_reset = 1'b0;
    reset = 1'b1;
    @(posedge move_clk);
    #1;
    reset = 1'b0;
    m_x = x; m_y = y; m_dir = (md == 1) ? 2 : 3; m_cnt = 0; m_step = 0;
  endtask

  // One clock: advance the model, compare all registered outputs and a fill probe.
  task automatic cycle_chk();
    int hc, vc, ef;
    @(posedge move_clk);
    if (level_reset) begin
      m_x = int'(xIni); m_y = int'(yIni); m_dir = (mode == 2'b01) ? 2 : 3;
      m_cnt = 0; m_step = 0;
    end else if (m_cnt == TD - 1) begin
      model_tick();
      m_cnt = 0; m_step = 1;
    end else begin
      m_cnt++; m_step = 0;
    end
    #1;
    chk("ghostX", int'(ghostX), m_x);
    chk("ghostY", int'(ghostY), m_y);
    chk("direction", int'(direction), m_dir);
    chk("step", int'(step), m_step);
    hc = m_x + OFH - HWD - 2 + $urandom_range(0, 2 * HWD + 4);
    vc = m_y + OFV - HWD - 2 + $urandom_range(0, 2 * HWD + 4);
    hCount = 10'(hc); vCount = 10'(vc);
    #1;
    ef = (absi(hc - (m_x + OFH)) <= HWD && absi(vc - (m_y + OFV)) <= HWD) ? 1 : 0;
    chk("ghostFill_probe", int'(ghostFill), ef);
  endtask

  task automatic run_ticks(input int n);
    repeat (n * TD) cycle_chk();
  endtask

  typedef struct {
    int h;
    int v;
    int exp;
  } fill_vec_t;

  fill_vec_t tbl[8];

  initial begin
    tbl[0] = '{383, 147, 1};
    tbl[1] = '{405, 169, 1};
    tbl[2] = '{382, 147, 0};
    tbl[3] = '{406, 169, 0};
    tbl[4] = '{394, 158, 1};
    tbl[5] = '{383, 146, 0};
    tbl[6] = '{405, 170, 0};
    tbl[7] = '{0, 0, 0};

    // Reset state and vertical patrol stepping.
    do_reset(120, 100, 0, 5);
    chk("rst_x", int'(ghostX), 120);
    chk("rst_y", int'(ghostY), 100);
    chk("rst_dir", int'(direction), 3);
    chk("rst_step", int'(step), 0);
    repeat (3) cycle_chk();
    chk("pre_tick_step", int'(step), 0);
    cycle_chk();
    chk("tick1_step", int'(step), 1);
    chk("tick1_y", int'(ghostY), 105);
    run_ticks(1);
    chk("tick2_y", int'(ghostY), 110);
    chk("tick2_x", int'(ghostX), 120);
    chk("tick2_dir", int'(direction), 3);

    // Vertical patrol hitting Y_MAX.
    do_reset(120, 320, 0, 5);
    run_ticks(1);
    chk("vmax_y", int'(ghostY), 322);
    chk("vmax_dir", int'(direction), 1);
    run_ticks(1);
    chk("vmax_back_y", int'(ghostY), 317);

    // Horizontal patrol: bounce off X_MAX, then clamp at X_MIN from 118.
    do_reset(128, 100, 1, 6);
    chk("hrst_dir", int'(direction), 2);
    run_ticks(6);
    chk("h_x122", int'(ghostX), 122);
    speed = 5'd4;
    run_ticks(1);
    chk("h_x118", int'(ghostX), 118);
    chk("h_dir_left", int'(direction), 0);
    speed = 5'd5;
    run_ticks(1);
    chk("hmin_x", int'(ghostX), 116);
    chk("hmin_dir", int'(direction), 2);
    run_ticks(1);
    chk("hmin_back_x", int'(ghostX), 121);

    // Chase.
    do_reset(120, 100, 2, 4);
    targetX = 10'd140; targetY = 10'd300;
    run_ticks(1);
    chk("chase_v_dir", int'(direction), 3);
    chk("chase_v_y", int'(ghostY), 104);
    targetX = 10'd140; targetY = 10'd100;
    run_ticks(1);
    chk("chase_h_dir", int'(direction), 2);
    chk("chase_h_x", int'(ghostX), 124);
    targetX = 10'd124; targetY = 10'd104;
    run_ticks(1);
    chk("chase_eq_x", int'(ghostX), 124);
    chk("chase_eq_y", int'(ghostY), 104);

    // Frozen, then level_reset coinciding with a tick.
    mode = 2'b11;
    run_ticks(1);
    chk("frz_step", int'(step), 1);
    chk("frz_x", int'(ghostX), 124);
    chk("frz_y", int'(ghostY), 104);
    repeat (3) cycle_chk();
    mode = 2'b00; speed = 5'd5; level_reset = 1'b1;
    cycle_chk();
    level_reset = 1'b0;
    chk("lr_x", int'(ghostX), 120);
    chk("lr_y", int'(ghostY), 100);
    chk("lr_dir", int'(direction), 3);
    chk("lr_step", int'(step), 0);
    repeat (3) cycle_chk();
    chk("lr_cnt_y", int'(ghostY), 100);
    cycle_chk();
    chk("lr_tick_y", int'(ghostY), 105);

    // Fill window table at (120,100), frozen so the position holds.
    do_reset(120, 100, 3, 5);
    for (int i = 0; i < 8; i++) begin
      hCount = 10'(tbl[i].h);
      vCount = 10'(tbl[i].v);
      #1;
      chk($sformatf("fill_tbl%0d", i), int'(ghostFill), tbl[i].exp);
    end

    // Randomized run against the model.
    do_reset($urandom_range(100, 160), $urandom_range(80, 340), $urandom_range(0, 3), 7);
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) speed = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) begin
        targetX = 10'($urandom_range(90, 170));
        targetY = 10'($urandom_range(60, 360));
      end
      if ($urandom_range(0, 19) == 0) begin
        xIni = 10'($urandom_range(90, 170));
        yIni = 10'($urandom_range(60, 360));
      end
      level_reset = ($urandom_range(0, 59) == 0);
      cycle_chk();
    end
    level_reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
